// File: rtl/alu_result_fifo.sv
// Registered in-order queue of ALU results (value, ovf/zero/neg flags, rd) feeding writeback, plus a sticky overflow bit.
// Latency: an entry pushed at edge N is on out_* with out_valid=1 in cycle N+1; there is no path from in_* to out_*.
// Backpressure: in_ready drops only when full, from registered state alone; a same-cycle pop does not reopen it.
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_out,
    input  logic          in_overflow,
    input  logic          in_zero,
    input  logic          in_negative,
    input  logic [4:0]    in_rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_out,
    output logic          out_overflow,
    output logic          out_zero,
    output logic          out_negative,
    output logic [4:0]    out_rd,
    output logic [AW:0]   count,
    output logic          ovf_sticky,
    input  logic          clear_sticky
);

    // Occupancy value that means "no free slot".
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    // Entry layout: {result[31:0], overflow, zero, negative, rd[4:0]}.
    logic [39:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic          sticky;
    logic          push;
    logic          pop;
    logic [39:0]   wr_entry;
    logic [39:0]   head_entry;

    // Handshake qualifiers; both depend only on registered occupancy plus the peer's request.
    always_comb begin
        in_ready  = (occ != FULL_COUNT);
        out_valid = (occ != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        wr_entry  = {in_out, in_overflow, in_zero, in_negative, in_rd};
    end

    // Storage is written only on an accepted push and never cleared; occupancy tracks validity.
    always_ff @(posedge clock) begin
        if (reset && push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                occ <= occ + 1'b1;
            end else if (pop && !push) begin
                occ <= occ - 1'b1;
            end
        end
    end

    // Sticky overflow: an accepted overflowing push beats a same-cycle clear; rejected pushes are invisible.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sticky <= 1'b0;
        end else if (push && in_overflow) begin
            sticky <= 1'b1;
        end else if (clear_sticky) begin
            sticky <= 1'b0;
        end
    end

    // Present the head entry, forcing all data and flags to zero while the queue is empty.
    always_comb begin
        head_entry   = out_valid ? mem[rd_ptr] : 40'd0;
        out_out      = head_entry[39:8];
        out_overflow = head_entry[7];
        out_zero     = head_entry[6];
        out_negative = head_entry[5];
        out_rd       = head_entry[4:0];
        count        = occ;
        ovf_sticky   = sticky;
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Bench for alu_result_fifo: queue-based reference model compared every cycle, plus directed literal checks.
// Latency: model entries become visible the cycle after the accepting edge.
// Backpressure: model accepts only while holding fewer than DEPTH entries.
module tb_alu_result_fifo;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_out;
    logic        in_overflow;
    logic        in_zero;
    logic        in_negative;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_out;
    logic        out_overflow;
    logic        out_zero;
    logic        out_negative;
    logic [4:0]  out_rd;
    logic [AW:0] count;
    logic        ovf_sticky;
    logic        clear_sticky;

    alu_result_fifo #(.DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_out      (in_out),
        .in_overflow (in_overflow),
        .in_zero     (in_zero),
        .in_negative (in_negative),
        .in_rd       (in_rd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_out     (out_out),
        .out_overflow(out_overflow),
        .out_zero    (out_zero),
        .out_negative(out_negative),
        .out_rd      (out_rd),
        .count       (count),
        .ovf_sticky  (ovf_sticky),
        .clear_sticky(clear_sticky)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] val;
        logic        ovf;
        logic        zro;
        logic        neg;
        logic [4:0]  rd;
    } entry_t;

    entry_t q[$];
    bit     m_sticky;
    bit     started;
    int     errors = 0;
    int     checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue updated at every rising edge from the sampled inputs.
    always @(posedge clock) begin
        bit     acc;
        bit     take;
        entry_t e;
        started = 1'b1;
        if (!reset) begin
            q.delete();
            m_sticky = 1'b0;
        end else begin
            acc  = in_valid && (q.size() < DEPTH);
            take = out_ready && (q.size() > 0);
            e    = '{val: in_out, ovf: in_overflow, zro: in_zero, neg: in_negative, rd: in_rd};
            if (take) void'(q.pop_front());
            if (acc) q.push_back(e);
            if (acc && in_overflow) m_sticky = 1'b1;
            else if (clear_sticky) m_sticky = 1'b0;
        end
    end

    // Per-cycle comparison against the model on the falling edge.
    always @(negedge clock) begin
        entry_t h;
        if (started) begin
            h = (q.size() > 0) ? q[0] : '0;
            chk("count",        32'(count),        32'(q.size()));
            chk("in_ready",     32'(in_ready),     32'(q.size() != DEPTH));
            chk("out_valid",    32'(out_valid),    32'(q.size() != 0));
            chk("out_out",      out_out,           h.val);
            chk("out_overflow", 32'(out_overflow), 32'(h.ovf));
            chk("out_zero",     32'(out_zero),     32'(h.zro));
            chk("out_negative", 32'(out_negative), 32'(h.neg));
            chk("out_rd",       32'(out_rd),       32'(h.rd));
            chk("ovf_sticky",   32'(ovf_sticky),   32'(m_sticky));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] d, input logic o, input logic z,
                          input logic n, input logic [4:0] r);
        in_valid    = v;
        in_out      = d;
        in_overflow = o;
        in_zero     = z;
        in_negative = n;
        in_rd       = r;
    endtask

    task automatic push1(input logic [31:0] d, input logic o, input logic z, input logic n,
                         input logic [4:0] r);
        set_in(1'b1, d, o, z, n, r);
        step();
        set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) step();
        out_ready = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        out_ready    = 1'b0;
        clear_sticky = 1'b0;
        set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);

        // Reset held for two edges.
        step();
        step();
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_out",   out_out,        32'd0);
        reset = 1'b1;

        // Basic push of 8+4 to rd 3.
        push1(32'd12, 1'b0, 1'b0, 1'b0, 5'd3);
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_out",   out_out,        32'd12);
        chk("basic_rd",    32'(out_rd),    32'd3);
        drain();

        // Flag pass-through: 2-5 negative, 5-5 zero.
        push1(32'hFFFF_FFFD, 1'b0, 1'b0, 1'b1, 5'd1);
        push1(32'd0,         1'b0, 1'b1, 1'b0, 5'd2);
        chk("flags_count", 32'(count),        32'd2);
        chk("flags_neg",   32'(out_negative), 32'd1);
        chk("flags_out0",  out_out,           32'hFFFF_FFFD);
        out_ready = 1'b1;
        step();
        chk("flags_zero", 32'(out_zero), 32'd1);
        chk("flags_rd2",  32'(out_rd),   32'd2);
        step();
        out_ready = 1'b0;
        chk("flags_empty_cnt", 32'(count), 32'd0);
        chk("flags_empty_out", out_out,    32'd0);

        // Fill, reject a fifth, then wrap.
        for (int i = 1; i <= 4; i++) push1(32'(i), 1'b0, 1'b0, 1'b0, 5'(i));
        chk("full_count", 32'(count),    32'd4);
        chk("full_ready", 32'(in_ready), 32'd0);
        push1(32'd99, 1'b1, 1'b0, 1'b0, 5'd9);
        chk("full_reject_cnt", 32'(count),      32'd4);
        chk("full_reject_ovf", 32'(ovf_sticky), 32'd0);
        // Pop while full with in_valid held: in_ready must stay low in that cycle.
        set_in(1'b1, 32'd77, 1'b0, 1'b0, 1'b0, 5'd7);
        out_ready = 1'b1;
        #1;
        chk("full_no_bypass", 32'(in_ready), 32'd0);
        step();
        set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        step();
        out_ready = 1'b0;
        push1(32'd5, 1'b0, 1'b0, 1'b0, 5'd5);
        push1(32'd6, 1'b0, 1'b0, 1'b0, 5'd6);
        out_ready = 1'b1;
        for (int i = 3; i <= 6; i++) begin
            chk("wrap_order", out_out, 32'(i));
            step();
        end
        out_ready = 1'b0;
        chk("wrap_empty", 32'(out_valid), 32'd0);

        // Simultaneous push and pop at count 2.
        push1(32'd10, 1'b0, 1'b0, 1'b0, 5'd10);
        push1(32'd11, 1'b0, 1'b0, 1'b0, 5'd11);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("sim_head", out_out, 32'(10 + i));
            set_in(1'b1, 32'(12 + i), 1'b0, 1'b0, 1'b0, 5'(12 + i));
            step();
            chk("sim_count", 32'(count), 32'd2);
        end
        set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("sim_tail0", out_out, 32'd13);
        step();
        chk("sim_tail1", out_out, 32'd14);
        step();
        out_ready = 1'b0;

        // Sticky overflow: 0x7FFFFFFF+1.
        push1(32'h8000_0000, 1'b1, 1'b0, 1'b1, 5'd4);
        chk("stk_set",   32'(ovf_sticky),   32'd1);
        chk("stk_flag",  32'(out_overflow), 32'd1);
        drain();
        clear_sticky = 1'b1;
        step();
        clear_sticky = 1'b0;
        chk("stk_clear", 32'(ovf_sticky), 32'd0);
        clear_sticky = 1'b1;
        push1(32'h8000_0000, 1'b1, 1'b0, 1'b1, 5'd4);
        clear_sticky = 1'b0;
        chk("stk_set_wins", 32'(ovf_sticky), 32'd1);
        drain();
        clear_sticky = 1'b1;
        step();
        clear_sticky = 1'b0;

        // Reset mid-operation with push and pop asserted.
        push1(32'd20, 1'b1, 1'b0, 1'b0, 5'd20);
        push1(32'd21, 1'b0, 1'b0, 1'b0, 5'd21);
        push1(32'd22, 1'b0, 1'b0, 1'b0, 5'd22);
        chk("mid_count3", 32'(count), 32'd3);
        set_in(1'b1, 32'd23, 1'b1, 1'b0, 1'b0, 5'd23);
        out_ready = 1'b1;
        reset     = 1'b0;
        step();
        reset     = 1'b1;
        out_ready = 1'b0;
        set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("mid_count",  32'(count),      32'd0);
        chk("mid_valid",  32'(out_valid),  32'd0);
        chk("mid_sticky", 32'(ovf_sticky), 32'd0);
        push1(32'd30, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("mid_first", out_out,        32'd30);
        chk("mid_rd0",   32'(out_rd),    32'd0);
        drain();

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_result_fifo.md
# alu_result_fifo

Registered result queue directly downstream of `alu32`. It captures each ALU result, its three status flags (overflow, zero, negative) and the destination register index into a small FIFO. It presents them in order to the writeback stage under a valid/ready handshake, so the execute stage can keep issuing while writeback stalls. It also keeps a sticky overflow status bit for exception logic.

## Interface
- `DEPTH`, 4: number of entries. Must be a power of two, ≥ 2.
- `AW`, `$clog2(DEPTH)`: pointer width. Derived; never overridden.

- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-low. Sampled on the rising edge of `clock`.
- `in_valid` in 1: ALU result on `in_*` is valid this cycle.
- `in_ready` out 1: FIFO can accept an entry this cycle.
- `in_out` in 32: ALU `out`.
- `in_overflow` in 1: ALU `overflow`.
- `in_zero` in 1: ALU `zero`.
- `in_negative` in 1: ALU `negative`.
- `in_rd` in 5: destination register index.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: writeback consumes head this cycle.
- `out_out` out 32: head result.
- `out_overflow` out 1: head overflow flag.
- `out_zero` out 1: head zero flag.
- `out_negative` out 1: head negative flag.
- `out_rd` out 5: head destination index.
- `count` out AW+1: current occupancy, 0..DEPTH.
- `ovf_sticky` out 1: set if any accepted entry had overflow since the last clear.
- `clear_sticky` in 1: clears `ovf_sticky`.

## Operation
- Storage is DEPTH entries of 40 bits: {out[31:0], overflow, zero, negative, rd[4:0]}. It is written only on push and is not reset.
- Push = `in_valid && in_ready`. Write the entry at `wr_ptr`, then `wr_ptr <= wr_ptr + 1`, wrapping modulo DEPTH.
- Pop = `out_valid && out_ready`. Then `rd_ptr <= rd_ptr + 1`, wrapping modulo DEPTH.
- `count` update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- `in_ready = (count != DEPTH)`. There is no full-time bypass: while full, a same-cycle pop does not open `in_ready`.
- `out_valid = (count != 0)`.
- Head data outputs:
  - While `out_valid`, `out_*` show the entry at `rd_ptr`.
  - While empty, all `out_*` data and flag outputs are forced to 0.
- Flag bits are stored exactly as received. The block never recomputes or modifies zero, negative or overflow.
- `in_rd = 0` is queued normally; suppressing writes to `$0` is writeback's responsibility.
- `ovf_sticky` next value:
  - Set when a push carries `in_overflow = 1`.
  - Cleared when `clear_sticky = 1`.
  - If set and clear occur in the same cycle, set wins.
  - `in_valid` with `in_ready = 0` (rejected entry) does not affect `ovf_sticky`.
- Ignored inputs:
  - Pop attempts with `count = 0` are ignored.
  - `in_valid` while full is ignored and not stored; upstream must hold the result.

## Timing
- Reset values (`reset` low at a rising edge):
  - `count` = 0, `wr_ptr` = `rd_ptr` = 0.
  - `out_valid` = 0, `in_ready` = 1.
  - All `out_*` = 0, `ovf_sticky` = 0.
- Reset takes priority over a push or pop in the same cycle. Any queued entries are discarded.
- Latency: an entry pushed at edge N is visible on `out_*` with `out_valid = 1` after edge N, i.e. in cycle N+1. No combinational path exists from `in_*` to `out_*`.
- Throughput: one push and one pop per cycle when 0 < `count` < DEPTH.
- Ordering is strictly FIFO.
- `in_ready` depends only on registered state, not on `out_ready`.
- The head is stable while `out_valid && !out_ready`.

## Test plan
- **Reset and basic push:** hold `reset` low for 2 cycles, then release.
  - During reset: `count` = 0, `in_ready` = 1, `out_valid` = 0, `out_out` = 0.
  - Push {12, ovf 0, zero 0, neg 0, rd 3} (8+4) → next cycle `out_valid` = 1, `out_out` = 12, `out_rd` = 3.
- **Flag pass-through:** push 2−5 = 0xFFFFFFFD with neg = 1, then 5−5 = 0 with zero = 1, holding `out_ready` = 0 → `count` = 2.
  - Raise `out_ready` → pops in order with flags intact, then `count` = 0 and `out_*` = 0.
- **Full and wrap-around:** push 4 entries (1, 2, 3, 4) with `out_ready` = 0 → `count` = 4 and `in_ready` = 0.
  - A 5th `in_valid` is not stored.
  - Then pop 2, push 5 and 6 → pop order 3, 4, 5, 6 (pointers wrap).
- **Simultaneous push and pop:** at `count` = 2, assert push and pop for 3 cycles → `count` stays 2 and output order is preserved.
- **Sticky overflow:**
  - Push 0x7FFFFFFF+1 (ovf = 1) → `ovf_sticky` = 1 the next cycle.
  - Assert `clear_sticky` alone → 0.
  - Assert `clear_sticky` together with an ovf = 1 push → stays 1.
- **Reset mid-operation:** with `count` = 3, drive `reset` low for one edge while a push and pop are asserted → `count` = 0, `out_valid` = 0, `ovf_sticky` = 0. The next push is output first.
